// File: rtl/control_display_7_seg_if.sv
// Bundle of the display data inputs and the anode/segment outputs.
// The master side (datapath / bench) drives the four hex digits and
// watches the pins; the slave side is the display driver itself.
interface control_display_7_seg_if;
  logic [3:0] i_Datos_1;
  logic [3:0] i_Datos_2;
  logic [3:0] i_Datos_3;
  logic [3:0] i_Datos_4;
  logic [3:0] o_Anodo;
  logic [6:0] o_Segmentos;

  modport master (
    output i_Datos_1, i_Datos_2, i_Datos_3, i_Datos_4,
    input  o_Anodo, o_Segmentos
  );

  modport slave (
    input  i_Datos_1, i_Datos_2, i_Datos_3, i_Datos_4,
    output o_Anodo, o_Segmentos
  );
endinterface

// File: rtl/control_display_7_seg.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler holds each digit for REFRESH_DIV clocks; the selected digit's
// anode (active-low) and its decoded segments (active-low, {g..a}) are
// registered, so pins change one clock after the index or the data moves.
module control_display_7_seg #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  control_display_7_seg_if.slave        io_Disp
);

  // A single-clock slot still needs a 1-bit counter that simply stays at 0.
  localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_Presc;
  logic [1:0]       r_Index;
  logic [3:0]       r_Anodo;
  logic [6:0]       r_Segmentos;
  logic             w_Last;
  logic [3:0]       w_Data;
  logic [3:0]       w_Anodo;

  // Hex to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign w_Last = (r_Presc == CNT_LAST);

  // Pick the live (unlatched) data for the digit currently being scanned.
  always_comb begin
    w_Data = 4'h0;
    case (r_Index)
      2'd0:    w_Data = io_Disp.i_Datos_1;
      2'd1:    w_Data = io_Disp.i_Datos_2;
      2'd2:    w_Data = io_Disp.i_Datos_3;
      2'd3:    w_Data = io_Disp.i_Datos_4;
      default: w_Data = 4'h0;
    endcase
  end

  assign w_Anodo = ~(4'b0001 << r_Index);

  // Prescaler and digit index; the index steps on the last clock of a slot.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      r_Presc <= '0;
      r_Index <= 2'd0;
    end else if (w_Last) begin
      r_Presc <= '0;
      r_Index <= r_Index + 2'd1;
    end else begin
      r_Presc <= r_Presc + {{(CNT_W-1){1'b0}}, 1'b1};
      r_Index <= r_Index;
    end
  end

  // Registered pin drive: blank during reset, otherwise the selected digit.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      r_Anodo     <= 4'b1111;
      r_Segmentos <= 7'h7F;
    end else begin
      r_Anodo     <= w_Anodo;
      r_Segmentos <= f_decode(w_Data);
    end
  end

  assign io_Disp.o_Anodo     = r_Anodo;
  assign io_Disp.o_Segmentos = r_Segmentos;

endmodule

// File: tb/tb_control_display_7_seg.sv
// Scoreboard bench for control_display_7_seg. Two instances share stimulus:
// A with a 4-clock slot and B with a 1-clock slot. A reference model derives
// each edge's expected pins from the count of edges since reset release and
// queues them; a monitor pops and compares one entry per DUT per clock.
module tb_control_display_7_seg;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       rst;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] d [4];

  int n_tests;
  int n_fail;
  int ka;
  int kb;

  exp_t qa [$];
  exp_t qb [$];

  control_display_7_seg_if if_a ();
  control_display_7_seg_if if_b ();

  assign if_a.i_Datos_1 = d[0];
  assign if_a.i_Datos_2 = d[1];
  assign if_a.i_Datos_3 = d[2];
  assign if_a.i_Datos_4 = d[3];
  assign if_b.i_Datos_1 = d[0];
  assign if_b.i_Datos_2 = d[1];
  assign if_b.i_Datos_3 = d[2];
  assign if_b.i_Datos_4 = d[3];

  control_display_7_seg #(.REFRESH_DIV(DIV_A)) u_dut_a (
    .i_Clk   (clk),
    .i_Rst   (rst_n),
    .io_Disp (if_a.slave)
  );

  control_display_7_seg #(.REFRESH_DIV(DIV_B)) u_dut_b (
    .i_Clk   (clk),
    .i_Rst   (rst_n),
    .io_Disp (if_b.slave)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected pins for an edge: k = edges since reset release, digit = (k/div) mod 4.
  function automatic exp_t model(input int k, input int div, input logic r);
    exp_t e;
    int   dig;
    if (!r) begin
      e.an  = 4'b1111;
      e.seg = 7'h7F;
      e.rst = 1'b1;
    end else begin
      dig   = (k / div) % 4;
      e.an  = 4'b1111;
      e.an[dig] = 1'b0;
      e.seg = SEG_TBL[d[dig]];
      e.rst = 1'b0;
    end
    return e;
  endfunction

  // Reference model: on each edge, predict and queue both DUTs' outputs.
  initial begin
    ka = 0;
    kb = 0;
    forever begin
      @(posedge clk);
      qa.push_back(model(ka, DIV_A, rst_n));
      qb.push_back(model(kb, DIV_B, rst_n));
      if (!rst_n) begin
        ka = 0;
        kb = 0;
      end else begin
        ka = ka + 1;
        kb = kb + 1;
      end
    end
  end

  // Monitor: just after every edge, pop the prediction and compare the pins.
  initial begin
    exp_t ea;
    exp_t eb;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() == 0 || qb.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("anodo_A", {28'd0, if_a.o_Anodo}, {28'd0, ea.an});
        chk("seg_A", {25'd0, if_a.o_Segmentos}, {25'd0, ea.seg});
        chk("anodo_B", {28'd0, if_b.o_Anodo}, {28'd0, eb.an});
        chk("seg_B", {25'd0, if_b.o_Segmentos}, {25'd0, eb.seg});
        if (!ea.rst) begin
          chk("onehot_A", $countones(~if_a.o_Anodo), 32'd1);
          chk("onehot_B", $countones(~if_b.o_Anodo), 32'd1);
          chk("noX", {31'd0, $isunknown({if_a.o_Anodo, if_a.o_Segmentos,
                                         if_b.o_Anodo, if_b.o_Segmentos})}, 32'd0);
        end
      end
    end
  end

  // Stimulus: reset, directed scan, mid-scan reset, decode sweep, random run.
  initial begin
    int guard;
    int v;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 4'h0;

    repeat (2) @(negedge clk);

    d[0] = 4'h9; d[1] = 4'h7; d[2] = 4'h5; d[3] = 4'h1;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    guard = 0;
    while (((ka / DIV_A) % 4) != 2 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_digit2", (guard < 64) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    v = 0;
    guard = 0;
    while (v < 16 && guard < 400) begin
      if (((ka / DIV_A) % 4) == 0) begin
        d[0] = 4'(v);
        v++;
      end
      @(negedge clk);
      guard++;
    end
    chk("sweep_done", (v == 16) ? 32'd1 : 32'd0, 32'd1);

    repeat (1000) begin
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom);
      rst_n = ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
